mul_seq: RTL and testbench
==========================

MUL_SEQ -- requirements
Module: mul_seq

Interface
REQ-001 Parameter: WIDTH, default 32, operand, result and ALU datapath width; only 32 is supported.
REQ-002 Port: clk  input  1  rising-edge clock; the block uses this single clock only.
REQ-003 Port: rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 Port: start  input  1  request to begin a multiply; accepted only in IDLE.
REQ-005 Port: opA  input  WIDTH  multiplicand, sampled on the accepted start cycle.
REQ-006 Port: opB  input  WIDTH  multiplier, sampled on the accepted start cycle.
REQ-007 Port: busy  output  1  high whenever the state is not IDLE.
REQ-008 Port: done  output  1  one-cycle pulse; result is valid while done is high.
REQ-009 Port: result  output  WIDTH  low WIDTH bits of opA*opB; held until the next accepted start.
REQ-010 Port: ALUop1  output  WIDTH  first operand to the shared ALU; carries the accumulator.
REQ-011 Port: ALUop2  output  WIDTH  second operand to the shared ALU; carries the shifted multiplicand.
REQ-012 Port: ALUctrl  output  3  ALU operation select; 3'b000 (ADD) in RUN, 3'b000 otherwise.
REQ-013 Port: SUM  input  WIDTH  combinational ALU result returned in the same cycle.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-015 Transition: IDLE->RUN when start=1; IDLE otherwise.
REQ-016 Transition: RUN->DONE on the cycle cnt=31; RUN otherwise.
REQ-017 Transition: DONE->IDLE unconditionally after one cycle.
REQ-018 On an accepted start: mcand<=opA, mplier<=opB, acc<=0 and cnt<=0.
REQ-019 In IDLE and DONE, ALUop1 and ALUop2 SHALL be driven to 0.
REQ-020 In RUN, ALUop1 and ALUop2 SHALL be driven combinationally from the acc and mcand registers.
REQ-021 Each RUN cycle: if mplier[0]=1, acc<=SUM; otherwise acc holds.
REQ-022 Each RUN cycle, in the same edge as REQ-021: mcand<=mcand<<1 (MSB discarded, zero fill), mplier<=mplier>>1 (zero fill), cnt<=cnt+1.
REQ-023 cnt SHALL be 5 bits wide; RUN SHALL always last exactly 32 cycles, with no early exit when mplier becomes 0.
REQ-024 Arithmetic is modulo 2^WIDTH: ALU carry-out and high product bits are discarded, and operands are treated as unsigned.
REQ-025 The DONE-state entry edge SHALL load result<=acc-final (including the last RUN cycle's add); done=1 only in DONE.
REQ-026 Latency: start sampled at edge N -> done=1 in the cycle after edge N+32 -> IDLE after edge N+33.
REQ-027 start while busy=1 (RUN or DONE) SHALL be ignored; operands and progress are unaffected.
REQ-028 Back-to-back operation: start SHALL first be accepted in the IDLE cycle following DONE; the minimum issue interval is 34 cycles.
REQ-029 The block SHALL ignore the EQ output of the ALU.

Reset
REQ-030 On rst=1 at a clk edge: state<=IDLE; acc, mcand, mplier, cnt and result<=0; done=0; busy=0.
REQ-031 rst SHALL take priority over start when both are asserted in the same cycle; the operation is not accepted.
REQ-032 rst in RUN or DONE SHALL abort the operation: no done pulse, result=0, and start is accepted on the cycle after rst deasserts.
REQ-033 With an external ALU connected, ALU outputs SHALL be 0 / ADD during and after reset until the next start.

Verification
REQ-034 opA=6, opB=7, start pulse at edge N -> busy=1 for 33 cycles, done=1 for exactly one cycle after edge N+32, result=42.
REQ-035 opA=0xFFFFFFFF, opB=0xFFFFFFFF -> result=0x00000001, exercising modulo wrap.
REQ-036 opA=0x00010000, opB=0x00010000 -> result=0x00000000; opA=0x80000000, opB=1 -> result=0x80000000.
REQ-037 3*5 started; start=1 with opA=9, opB=9 asserted at RUN cycle 10 and in the DONE cycle -> result=15; a start in the following IDLE cycle then yields 81.
REQ-038 rst=1 at RUN cycle 20 -> next cycle busy=0, done=0, result=0, ALUop1=0, ALUop2=0; no done pulse occurs in the following 40 cycles.
REQ-039 Reference model check: at least 1000 random opA/opB pairs -> result equals (opA*opB) mod 2^32, ALUctrl=3'b000 every cycle, done pulse width=1.

Source files
------------

// File: rtl/mul_seq.sv
// Purpose: 32-bit unsigned shift-and-add multiplier that borrows an external ALU for its adds.
// Latency: start accepted at edge N -> done pulse after edge N+32 -> idle again after edge N+33.
// Backpressure: none; start is accepted only while idle, and a start while busy is dropped.
//
// Ports:
//   clk, rst        single clock, synchronous active-high reset
//   start, opA, opB multiply request; opA/opB are captured on the accepted start cycle
//   busy, done      busy while not idle; done is a one-cycle pulse while result is fresh
//   result          low WIDTH bits of opA*opB, held until the next result is produced
//   ALUop1, ALUop2  operands to the shared ALU (accumulator, shifted multiplicand); zero when not running
//   ALUctrl         ALU operation select; ADD (3'b000) at all times
//   SUM             combinational ALU result for ALUop1 + ALUop2, returned in the same cycle
module mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] ALUop1,
  output logic [WIDTH-1:0] ALUop2,
  output logic [2:0]       ALUctrl,
  input  logic [WIDTH-1:0] SUM
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [4:0] CNT_LAST = 5'd31;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [4:0]       cnt;
  logic [WIDTH-1:0] acc_nxt;

  // Partial product update: add the shifted multiplicand only when the
  // current multiplier bit is set. The ALU carry-out is not available to
  // us and not wanted, so arithmetic wraps modulo 2^WIDTH naturally.
  assign acc_nxt = mplier[0] ? SUM : acc;

  // The ALU is only driven while running so it sees quiet zero operands
  // in idle, done and reset.
  assign ALUop1  = (state == RUN) ? acc   : '0;
  assign ALUop2  = (state == RUN) ? mcand : '0;
  assign ALUctrl = ALU_ADD;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      result <= '0;
      done   <= 1'b0;
      busy   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state  <= RUN;
            mcand  <= opA;
            mplier <= opB;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
          end
        end

        RUN: begin
          // Always 32 iterations; no early exit when mplier runs out of ones,
          // which keeps the latency fixed for the caller.
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 5'd1;
          if (cnt == CNT_LAST) begin
            state  <= DONE;
            // Capture the post-add value of the final iteration directly.
            result <= acc_nxt;
            done   <= 1'b1;
          end
        end

        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq.sv
// Purpose: self-checking bench for mul_seq with an ideal external adder as the ALU.
// Latency: checks the fixed 33-cycle busy window and the single-cycle done pulse.
// Backpressure: exercises ignored starts while busy and reset aborts.
module tb_mul_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] opA;
  logic [31:0] opB;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [31:0] ALUop1;
  logic [31:0] ALUop2;
  logic [2:0]  ALUctrl;
  logic [31:0] SUM;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  mul_seq #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .opA    (opA),
    .opB    (opB),
    .busy   (busy),
    .done   (done),
    .result (result),
    .ALUop1 (ALUop1),
    .ALUop2 (ALUop2),
    .ALUctrl(ALUctrl),
    .SUM    (SUM)
  );

  // External ALU: only ADD is ever requested, carry-out dropped.
  assign SUM = ALUop1 + ALUop2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------
  // Behavioural model: a busy window of 33 cycles after an accepted
  // start, with the product known up front from plain arithmetic.
  // ---------------------------------------------------------------
  logic        m_busy;
  logic        m_done;
  logic [31:0] m_result;
  logic [31:0] m_prod;
  logic [31:0] m_a;
  logic [31:0] m_b;
  int          m_left;

  always @(posedge clk) begin
    if (rst) begin
      m_busy   <= 1'b0;
      m_done   <= 1'b0;
      m_result <= '0;
      m_left   <= 0;
    end else if (!m_busy) begin
      m_done <= 1'b0;
      if (start) begin
        m_busy <= 1'b1;
        m_left <= 33;
        m_a    <= opA;
        m_b    <= opB;
        m_prod <= opA * opB;
      end
    end else begin
      m_left <= m_left - 1;
      if (m_left == 2) begin
        m_done   <= 1'b1;
        m_result <= m_prod;
      end
      if (m_left == 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model. While running, after k
  // iterations the ALU must see the partial product of the low k
  // multiplier bits and the multiplicand scaled by 2^k.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", {31'd0, busy}, {31'd0, m_busy});
      chk("done", {31'd0, done}, {31'd0, m_done});
      chk("result", result, m_result);
      chk("aluctrl", {29'd0, ALUctrl}, 32'd0);
      if (m_busy && !m_done) begin
        int          k;
        logic [63:0] mask;
        logic [31:0] pp;
        logic [31:0] sh;
        k    = 33 - m_left;
        mask = (64'd1 << k) - 64'd1;
        pp   = m_a * (m_b & mask[31:0]);
        sh   = m_a << k;
        chk("aluop1_run", ALUop1, pp);
        chk("aluop2_run", ALUop2, sh);
      end else begin
        chk("aluop1_quiet", ALUop1, 32'd0);
        chk("aluop2_quiet", ALUop2, 32'd0);
      end
    end
  end

  // Issue one multiply and check latency, result and pulse width.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input string nm);
    int cyc;
    @(negedge clk);
    opA   = a;
    opB   = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk({nm, "_latency"}, cyc, 32'd33);
    chk(nm, result, exp);
    @(negedge clk);
    chk({nm, "_pulse"}, {31'd0, done}, 32'd0);
    chk({nm, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int          cyc;
    int          busy_cnt;
    int          done_seen;
    logic [31:0] ra;
    logic [31:0] rb;

    rst   = 1'b1;
    start = 1'b1;
    opA   = 32'h1234_5678;
    opB   = 32'h9abc_def0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    // Reset state with start held high: must not be accepted.
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_aluop1", ALUop1, 32'd0);
    chk("rst_aluop2", ALUop2, 32'd0);
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("rst_prio_busy", {31'd0, busy}, 32'd0);

    // 6*7 with an explicit busy-width count.
    @(negedge clk);
    opA = 32'd6; opB = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy_cnt = 0; done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_seen++;
        chk("r6x7", result, 32'd42);
      end
      @(negedge clk);
    end
    chk("busy_width", busy_cnt, 32'd33);
    chk("done_width", done_seen, 32'd1);

    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, "wrap_ff");
    run_op(32'h0001_0000, 32'h0001_0000, 32'h0000_0000, "hi_lost");
    run_op(32'h8000_0000, 32'h0000_0001, 32'h8000_0000, "msb");
    run_op(32'd0, 32'hDEAD_BEEF, 32'd0, "zero_a");
    run_op(32'd1000, 32'd1000, 32'd1000000, "thousand");

    // Starts while busy are ignored; first IDLE start is accepted.
    @(negedge clk);
    opA = 32'd3; opB = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (cyc < 11) begin @(negedge clk); cyc++; end
    opA = 32'd9; opB = 32'd9; start = 1'b1;
    @(negedge clk);
    cyc++;
    start = 1'b0;
    while (!done && cyc < 40) begin @(negedge clk); cyc++; end
    chk("ign_latency", cyc, 32'd33);
    chk("ign_result", result, 32'd15);
    start = 1'b1;   // held through the DONE cycle into the next IDLE cycle
    @(negedge clk);
    chk("ign_done_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    start = 1'b0;
    chk("reissue_busy", {31'd0, busy}, 32'd1);
    cyc = 1;
    while (!done && cyc < 40) begin @(negedge clk); cyc++; end
    chk("reissue_latency", cyc, 32'd33);
    chk("reissue_result", result, 32'd81);
    @(negedge clk);

    // Reset mid-run aborts with no pulse.
    @(negedge clk);
    opA = 32'd11; opB = 32'd13; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (cyc < 21) begin @(negedge clk); cyc++; end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_result", result, 32'd0);
    chk("abort_aluop1", ALUop1, 32'd0);
    chk("abort_aluop2", ALUop2, 32'd0);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    chk("abort_no_pulse", done_seen, 32'd0);

    // Random pairs against plain multiplication.
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 7 == 0) rb = $urandom_range(0, 15);
      run_op(ra, rb, ra * rb, "rand");
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
